router_reg: RTL

// Datapath register stage of the 1x3 router, directly downstream of the router FSM.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_parity_acc.sv | 36 +++
 rtl/router_reg.sv | 94 +++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: datapath widths, address encoding and FSM state names.
package router_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W     = 2;
   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      DECODE_ADDR,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      WAIT_TILL_EMPTY,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      LOAD_PARITY,
      CHECK_PARITY_ERROR
   } fsm_state_e;

   // Address 3 has no output FIFO behind it.
   function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
      return addr != ADDR_INVALID;
   endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity over header and payload, capture of the packet parity byte, and their comparison.
module router_parity_acc
   import router_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clr,
   input  logic              acc_en,
   input  logic              cap_en,
   input  logic [DATA_W-1:0] din,
   output logic              mismatch
);

   logic [DATA_W-1:0] int_parity;
   logic [DATA_W-1:0] pkt_parity;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         int_parity <= '0;
         pkt_parity <= '0;
      end else begin
         if (clr)
            int_parity <= '0;
         else if (acc_en)
            int_parity <= int_parity ^ din;
         if (cap_en)
            pkt_parity <= din;
      end
   end

   assign mismatch = (int_parity != pkt_parity);

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, one-byte stall buffer, output byte and packet status flags.
module router_reg
   import router_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] din,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              rst_int_reg,
   output logic [DATA_W-1:0] dout,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              err
);

   logic [DATA_W-1:0] header;
   logic [DATA_W-1:0] hold;
   logic              mismatch;

   // Strobes reduced to one-hot with priority detect_add > lfd > ld > laf; FIFO_FULL_STATE freezes everything.
   logic run, s_da, s_lfd, s_ld, s_laf, s_rir;
   assign run   = !full_state;
   assign s_da  = run & detect_add;
   assign s_lfd = run & lfd_state & !detect_add;
   assign s_ld  = run & ld_state & !detect_add & !lfd_state;
   assign s_laf = run & laf_state & !detect_add & !lfd_state & !ld_state;
   assign s_rir = run & rst_int_reg;

   logic [DATA_W-1:0] acc_byte;
   assign acc_byte = s_lfd ? header : din;

   router_parity_acc #(.DATA_W(DATA_W)) u_parity (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (s_da),
      .acc_en   (s_lfd | (s_ld & pkt_valid)),
      .cap_en   (s_ld & !pkt_valid),
      .din      (acc_byte),
      .mismatch (mismatch)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         header <= '0;
         hold   <= '0;
         dout   <= '0;
      end else begin
         if (s_da & pkt_valid & addr_valid(din[ADDR_W-1:0]))
            header <= din;
         // A byte arriving while the FIFO is full is parked once and replayed in LOAD_AFTER_FULL.
         if (s_ld & fifo_full)
            hold <= din;
         if (s_lfd)
            dout <= header;
         else if (s_ld & !fifo_full)
            dout <= din;
         else if (s_laf)
            dout <= hold;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         parity_done   <= 1'b0;
         low_pkt_valid <= 1'b0;
         err           <= 1'b0;
      end else begin
         if (s_ld & !pkt_valid)
            low_pkt_valid <= 1'b1;
         else if (s_rir)
            low_pkt_valid <= 1'b0;

         if (s_da)
            parity_done <= 1'b0;
         else if ((s_ld & !fifo_full & !pkt_valid) | (s_laf & low_pkt_valid & !parity_done))
            parity_done <= 1'b1;

         // Error stays visible to the FSM until a new packet header is accepted.
         if (s_rir)
            err <= mismatch;
         else if (s_da & pkt_valid)
            err <= 1'b0;
      end
   end

endmodule
